// File: rtl/lc3_seq_ctrl.sv
// LC-3 control-path state sequencer: fetch/decode/execute, TRAP, RTI, interrupt and exception entry.
// Optional memory-ready timeout compiled in with `define LC3_SEQ_TIMEOUT_EN.
module lc3_seq_ctrl #(
    parameter int STATE_W     = 6,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        IR,
    input  logic               R,
    input  logic               N,
    input  logic               Z,
    input  logic               P,
    input  logic               INT,
    input  logic               PSR15,
    output logic [STATE_W-1:0] state,
    output logic               mem_en,
    output logic               mem_we,
    output logic               ben,
    output logic [1:0]         exc_cause,
    output logic               bus_err
);

    typedef enum logic [STATE_W-1:0] {
        S0  = STATE_W'(0),  S1  = STATE_W'(1),  S2  = STATE_W'(2),  S3  = STATE_W'(3),
        S4  = STATE_W'(4),  S5  = STATE_W'(5),  S6  = STATE_W'(6),  S7  = STATE_W'(7),
        S8  = STATE_W'(8),  S9  = STATE_W'(9),  S10 = STATE_W'(10), S11 = STATE_W'(11),
        S12 = STATE_W'(12), S13 = STATE_W'(13), S14 = STATE_W'(14), S15 = STATE_W'(15),
        S16 = STATE_W'(16), S18 = STATE_W'(18), S20 = STATE_W'(20), S21 = STATE_W'(21),
        S22 = STATE_W'(22), S23 = STATE_W'(23), S24 = STATE_W'(24), S25 = STATE_W'(25),
        S26 = STATE_W'(26), S27 = STATE_W'(27), S28 = STATE_W'(28), S29 = STATE_W'(29),
        S30 = STATE_W'(30), S31 = STATE_W'(31), S32 = STATE_W'(32), S33 = STATE_W'(33),
        S34 = STATE_W'(34), S35 = STATE_W'(35), S36 = STATE_W'(36), S37 = STATE_W'(37),
        S38 = STATE_W'(38), S39 = STATE_W'(39), S40 = STATE_W'(40), S41 = STATE_W'(41),
        S42 = STATE_W'(42), S43 = STATE_W'(43), S44 = STATE_W'(44), S45 = STATE_W'(45),
        S47 = STATE_W'(47), S48 = STATE_W'(48), S49 = STATE_W'(49), S50 = STATE_W'(50),
        S51 = STATE_W'(51), S52 = STATE_W'(52), S54 = STATE_W'(54), S57 = STATE_W'(57),
        S59 = STATE_W'(59)
    } state_e;

    state_e     state_q, state_d;
    logic       ben_q, ben_d;
    logic [1:0] exc_q, exc_d;
    logic       tmo;
    logic       unused_ir;

    assign unused_ir = ^IR[8:0];

    always_comb begin
        mem_en = 1'b0;
        mem_we = 1'b0;
        case (state_q)
            S33, S28, S25, S24, S29, S36, S40, S48, S52: mem_en = 1'b1;
            S16, S41, S47: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef LC3_SEQ_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q;

    assign tmo = mem_en && !R && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    // Any state change restarts the count, so every memory state starts at zero.
    assign cnt_d = (state_d != state_q) ? '0 : (!R ? cnt_q + 1'b1 : cnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= tmo;
        end
    end
    assign bus_err = bus_err_q;
`else
    localparam int unused_cfg = TIMEOUT_CYC + CNT_W;
    assign tmo     = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_comb begin
        state_d = S18;
        case (state_q)
            S0:  state_d = ben_q ? S22 : S18;
            S1, S5, S9, S12, S14, S20, S21, S22, S16, S27, S30, S51, S54, S59: state_d = S18;
            S2, S6:    state_d = S25;
            S3, S7, S31: state_d = S23;
            S4:  state_d = IR[11] ? S21 : S20;
            S8:  state_d = PSR15 ? S44 : S36;
            S10: state_d = S24;
            S11: state_d = S29;
            S13, S49: state_d = PSR15 ? S45 : S37;
            S15: state_d = S28;
            S18: state_d = INT ? S49 : S33;
            S23: state_d = S16;
            S24: state_d = S26;
            S25: state_d = S27;
            S26: state_d = S25;
            S28: state_d = S30;
            S29: state_d = S31;
            S32: state_d = state_e'(STATE_W'(IR[15:12]));
            S33: state_d = S35;
            S34: state_d = PSR15 ? S59 : S51;
            S35: state_d = S32;
            S36: state_d = S38;
            S37: state_d = S41;
            S38: state_d = S39;
            S39: state_d = S40;
            S40: state_d = S42;
            S41: state_d = S43;
            S42: state_d = S34;
            S43: state_d = S47;
            S44: state_d = S45;
            S45: state_d = S37;
            S47: state_d = S48;
            S48: state_d = S50;
            S50: state_d = S52;
            S52: state_d = S54;
`ifdef LC3_SEQ_TIMEOUT_EN
            S57: state_d = PSR15 ? S45 : S37;
`endif
            default: state_d = S18;
        endcase
        // Memory states hold until ready; R=1 in the timeout cycle still wins.
        if (mem_en && !R) state_d = tmo ? S57 : state_q;
    end

    always_comb begin
        ben_d = ben_q;
        if (state_q == S32) ben_d = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
        exc_d = exc_q;
        if (state_d != state_q) begin
            case (state_d)
                S49:      exc_d = 2'd1;
                S13, S44: exc_d = 2'd2;
                S57:      exc_d = 2'd3;
                S54:      exc_d = 2'd0;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S18;
            ben_q   <= 1'b0;
            exc_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ben_q   <= ben_d;
            exc_q   <= exc_d;
        end
    end

    assign state     = state_q;
    assign ben       = ben_q;
    assign exc_cause = exc_q;

endmodule

// File: tb/tb_lc3_seq_ctrl.sv
// Bench for lc3_seq_ctrl: directed test-plan sequences plus random stimulus against a table-driven model.
module tb_lc3_seq_ctrl;
`ifdef LC3_SEQ_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] IR = '0;
    logic        R = 1'b1, N = 1'b0, Z = 1'b0, P = 1'b0, INT = 1'b0, PSR15 = 1'b0;
    logic [5:0]  state;
    logic        mem_en, mem_we, ben, bus_err;
    logic [1:0]  exc_cause;

    lc3_seq_ctrl #(.STATE_W(6), .TIMEOUT_CYC(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .IR(IR), .R(R), .N(N), .Z(Z), .P(P), .INT(INT), .PSR15(PSR15),
        .state(state), .mem_en(mem_en), .mem_we(mem_we), .ben(ben),
        .exc_cause(exc_cause), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int tbl[64];
    bit is_rd[64], is_wr[64];
    int m_state, m_ben, m_cause, m_cnt, m_bus;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void init_model();
        int rd[9] = '{33, 28, 25, 24, 29, 36, 40, 48, 52};
        int wr[3] = '{16, 41, 47};
        int to18[14] = '{1, 5, 9, 12, 14, 20, 21, 22, 16, 27, 30, 51, 54, 59};
        for (int i = 0; i < 64; i++) begin tbl[i] = 18; is_rd[i] = 0; is_wr[i] = 0; end
        foreach (rd[i]) is_rd[rd[i]] = 1;
        foreach (wr[i]) is_wr[wr[i]] = 1;
        foreach (to18[i]) tbl[to18[i]] = 18;
        tbl[2] = 25; tbl[6] = 25; tbl[3] = 23; tbl[7] = 23; tbl[31] = 23; tbl[10] = 24;
        tbl[11] = 29; tbl[15] = 28; tbl[23] = 16; tbl[24] = 26; tbl[25] = 27; tbl[26] = 25;
        tbl[28] = 30; tbl[29] = 31; tbl[33] = 35; tbl[35] = 32; tbl[36] = 38; tbl[37] = 41;
        tbl[38] = 39; tbl[39] = 40; tbl[40] = 42; tbl[41] = 43; tbl[42] = 34; tbl[43] = 47;
        tbl[44] = 45; tbl[45] = 37; tbl[47] = 48; tbl[48] = 50; tbl[50] = 52; tbl[52] = 54;
    endfunction

    function automatic void model_reset();
        m_state = 18; m_ben = 0; m_cause = 0; m_cnt = 0; m_bus = 0;
    endfunction

    function automatic int model_next(int s);
        case (s)
            0:       return m_ben ? 22 : 18;
            4:       return IR[11] ? 21 : 20;
            8:       return PSR15 ? 44 : 36;
            13, 49:  return PSR15 ? 45 : 37;
`ifdef LC3_SEQ_TIMEOUT_EN
            57:      return PSR15 ? 45 : 37;
`endif
            18:      return INT ? 49 : 33;
            32:      return int'(IR[15:12]);
            34:      return PSR15 ? 59 : 51;
            default: return tbl[s];
        endcase
    endfunction

    function automatic void model_clock();
        int s = m_state, nx;
        m_bus = 0;
        if ((is_rd[s] || is_wr[s]) && !R) begin
            nx = s;
`ifdef LC3_SEQ_TIMEOUT_EN
            if (m_cnt == TO - 1) begin nx = 57; m_bus = 1; end
`endif
        end else nx = model_next(s);
        if (s == 32) m_ben = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
        if (nx != s) begin
            m_cnt = 0;
            if (nx == 49) m_cause = 1;
            else if (nx == 13 || nx == 44) m_cause = 2;
            else if (nx == 57) m_cause = 3;
            else if (nx == 54) m_cause = 0;
        end else if (!R) m_cnt++;
        m_state = nx;
    endfunction

    task automatic step(input logic [15:0] ir, input logic r, input logic [2:0] nzp,
                        input logic intr, input logic psr);
        IR = ir; R = r; {N, Z, P} = nzp; INT = intr; PSR15 = psr;
        @(posedge clk);
        model_clock();
        #1;
        chk("state", state, m_state);
        chk("mem_en", mem_en, is_rd[m_state] | is_wr[m_state]);
        chk("mem_we", mem_we, is_wr[m_state]);
        chk("ben", ben, m_ben);
        chk("exc_cause", exc_cause, m_cause);
        chk("bus_err", bus_err, m_bus);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_state", state, 18);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_ben", ben, 0);
        chk("rst_cause", exc_cause, 0);
        chk("rst_bus_err", bus_err, 0);
        rst = 1'b0;
    endtask

    initial begin
        int add_seq[5] = '{33, 35, 32, 1, 18};
        int int_seq[10] = '{45, 37, 41, 43, 47, 48, 50, 52, 54, 18};
        init_model();
        do_reset();

        // ADD, zero-wait memory
        foreach (add_seq[i]) begin
            step(16'h1042, 1'b1, 3'b000, 1'b0, 1'b0);
            chk("add_walk", state, add_seq[i]);
        end

        // BRnp taken with N, not taken with Z
        repeat (4) step(16'h0A05, 1'b1, 3'b100, 1'b0, 1'b0);
        chk("br_taken_ben", ben, 1);
        chk("br_state0", state, 0);
        step(16'h0A05, 1'b1, 3'b100, 1'b0, 1'b0);
        chk("br_to22", state, 22);
        step(16'h0A05, 1'b1, 3'b100, 1'b0, 1'b0);
        repeat (4) step(16'h0A05, 1'b1, 3'b010, 1'b0, 1'b0);
        chk("br_nt_ben", ben, 0);
        step(16'h0A05, 1'b1, 3'b010, 1'b0, 1'b0);
        chk("br_nt_to18", state, 18);

        // ST with 3 wait cycles in 16
        repeat (6) step(16'h3000, 1'b1, 3'b000, 1'b0, 1'b0);
        chk("st_in16", state, 16);
        repeat (3) begin
            step(16'h3000, 1'b0, 3'b000, 1'b0, 1'b0);
            chk("st_hold16", state, 16);
            chk("st_we", mem_we, 1);
        end
        step(16'h3000, 1'b1, 3'b000, 1'b0, 1'b0);
        chk("st_done", state, 18);

        // Interrupt from user mode
        step(16'h1042, 1'b1, 3'b000, 1'b1, 1'b1);
        chk("int_49", state, 49);
        chk("int_cause", exc_cause, 1);
        foreach (int_seq[i]) begin
            step(16'h1042, 1'b1, 3'b000, 1'b0, 1'b1);
            chk("int_walk", state, int_seq[i]);
            chk("int_cause_walk", exc_cause, (int_seq[i] == 54 || int_seq[i] == 18) ? 0 : 1);
        end

`ifdef LC3_SEQ_TIMEOUT_EN
        step(16'h1042, 1'b0, 3'b000, 1'b0, 1'b0);
        repeat (3) begin
            step(16'h1042, 1'b0, 3'b000, 1'b0, 1'b0);
            chk("to_hold33", state, 33);
        end
        step(16'h1042, 1'b0, 3'b000, 1'b0, 1'b0);
        chk("to_57", state, 57);
        chk("to_bus_err", bus_err, 1);
        chk("to_cause", exc_cause, 3);
        step(16'h1042, 1'b0, 3'b000, 1'b0, 1'b0);
        chk("to_37", state, 37);
        chk("to_bus_err_clr", bus_err, 0);
        do_reset();
`endif

        // Reset during a stalled LD access
        repeat (5) step(16'h2000, 1'b1, 3'b000, 1'b0, 1'b0);
        chk("ld_in25", state, 25);
        R = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_state", state, 18);
        chk("async_rst_mem_en", mem_en, 0);
        do_reset();

        // Random stimulus
        for (int i = 0; i < 4000; i++)
            step(16'($urandom), ($urandom_range(3) != 0), 3'($urandom),
                 ($urandom_range(7) == 0), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
